// File: rtl/gray_stream_decoder.sv
// Reflected-Gray stream decoder with single-bit-step checking.
// One output register (1-cycle latency, full throughput) holds the binary
// value, the count direction and a step-error flag; a saturating counter
// tallies step errors since the last reset or clear.
module gray_stream_decoder #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dir,
  output logic             o_step_err,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q;
  logic             accept;
  logic [WIDTH-1:0] bin_new, bin_prev, bin_inc, diff;
  logic             dir_d, err_d, cnt_inc;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      b[WIDTH-1-k] = b[WIDTH-k] ^ g[WIDTH-1-k];
    end
    return b;
  endfunction

  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign o_locked = (state_q == TRACK);

  // Next state plus per-beat classification of the incoming sample.
  // Clear wins over history: an accept alongside i_clr is a first sample.
  always_comb begin
    state_d  = state_q;
    dir_d    = o_dir;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    bin_new  = gray2bin(i_data);
    bin_prev = gray2bin(ref_q);
    bin_inc  = bin_prev + WIDTH'(1);
    diff     = i_data ^ ref_q;
    if (i_clr) begin
      state_d = IDLE;
    end
    if (accept) begin
      state_d = TRACK;
      if (i_clr || state_q == IDLE) begin
        dir_d = 1'b1;
      end else if (diff == '0) begin
        dir_d = o_dir;
      end else if ((diff & (diff - WIDTH'(1))) == '0) begin
        dir_d = (bin_new == bin_inc);
      end else begin
        err_d   = 1'b1;
        dir_d   = 1'b0;
        cnt_inc = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register, stored reference and saturating error counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_dir      <= 1'b0;
      o_step_err <= 1'b0;
      ref_q      <= '0;
      o_err_cnt  <= '0;
    end else begin
      if (accept) begin
        o_valid    <= 1'b1;
        o_data     <= bin_new;
        o_dir      <= dir_d;
        o_step_err <= err_d;
        ref_q      <= i_data;
      end else if (i_ready) begin
        o_valid    <= 1'b0;
      end
      if (i_clr) begin
        o_err_cnt <= '0;
      end else if (cnt_inc && o_err_cnt != '1) begin
        o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: directed scenarios followed by random
// traffic, all checked against a behavioural model of the output register.
module tb_gray_stream_decoder;
  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rstn, clr, vld, rdy;
  logic [W-1:0] din;
  logic         o_ready, o_valid, o_dir, o_step_err, o_locked;
  logic [W-1:0] o_data;
  logic [7:0]   o_err_cnt;
  logic         o_ready2, o_valid2, o_dir2, o_step_err2, o_locked2;
  logic [W-1:0] o_data2;
  logic [1:0]   o_err_cnt2;

  gray_stream_decoder #(.WIDTH(W), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_valid(vld), .o_ready(o_ready),
    .i_data(din), .o_valid(o_valid), .i_ready(rdy), .o_data(o_data),
    .o_dir(o_dir), .o_step_err(o_step_err), .o_locked(o_locked),
    .o_err_cnt(o_err_cnt)
  );

  gray_stream_decoder #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_valid(vld), .o_ready(o_ready2),
    .i_data(din), .o_valid(o_valid2), .i_ready(rdy), .o_data(o_data2),
    .o_dir(o_dir2), .o_step_err(o_step_err2), .o_locked(o_locked2),
    .o_err_cnt(o_err_cnt2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model of what the output register and status should hold.
  bit m_valid, m_dir, m_err, m_lock;
  int m_data, m_ref, m_cnt, m_cnt2;
  int prev_g;

  function automatic int g2b(input int g);
    int b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b & MASK;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_data", 32'(o_data), 32'(m_data));
    chk("o_dir", 32'(o_dir), 32'(m_dir));
    chk("o_step_err", 32'(o_step_err), 32'(m_err));
    chk("o_locked", 32'(o_locked), 32'(m_lock));
    chk("o_err_cnt", 32'(o_err_cnt), 32'(m_cnt));
    chk("sat_err_cnt", 32'(o_err_cnt2), 32'(m_cnt2));
    chk("sat_valid", 32'(o_valid2), 32'(m_valid));
  endtask

  task automatic model_reset();
    m_valid = 0; m_dir = 0; m_err = 0; m_lock = 0;
    m_data = 0; m_ref = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock cycle of traffic: drive, check ready, clock, update model, check.
  task automatic step(input bit v, input int d, input bit r, input bit c);
    bit exp_rdy, acc;
    int bn, hd;
    @(negedge clk);
    vld = v; din = W'(d); rdy = r; clr = c;
    #1;
    exp_rdy = !m_valid || r;
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc) begin
      bn = g2b(d);
      if (c || !m_lock) begin
        m_err = 0; m_dir = 1;
      end else begin
        hd = $countones(W'(d ^ m_ref));
        if (hd == 0) begin
          m_err = 0;
        end else if (hd == 1) begin
          m_err = 0;
          m_dir = (((bn - g2b(m_ref)) & MASK) == 1);
        end else begin
          m_err = 1; m_dir = 0;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      m_valid = 1; m_data = bn; m_ref = d; m_lock = 1; prev_g = d;
    end else begin
      if (r) m_valid = 0;
      if (c) m_lock = 0;
    end
    if (c) begin
      m_cnt = 0; m_cnt2 = 0;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0; vld = 1'b0; clr = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    int d, bp, sel;
    rstn = 1'b0; clr = 1'b0; vld = 1'b0; rdy = 1'b1; din = '0;
    prev_g = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // Ascending full cycle with wrap 7 -> 0.
    for (int i = 0; i < 9; i++) begin
      step(1, gseq[i], 1, 0);
      chk("up_bin", 32'(o_data), 32'(i % 8));
      chk("up_dir", 32'(o_dir), 32'd1);
      chk("up_err", 32'(o_step_err), 32'd0);
    end
    chk("up_cnt", 32'(o_err_cnt), 32'd0);

    // Descending, including the 0 -> 7 wrap.
    do_reset();
    for (int i = 8; i >= 0; i--) begin
      step(1, gseq[i], 1, 0);
      chk("dn_bin", 32'(o_data), 32'((8 - (8 - i)) % 8 == 0 ? 0 : i));
      chk("dn_dir", 32'(o_dir), 32'(i == 8 ? 1 : 0));
      chk("dn_err", 32'(o_step_err), 32'd0);
    end
    chk("dn_cnt", 32'(o_err_cnt), 32'd0);

    // Step error then resynchronised legal step.
    do_reset();
    step(1, 0, 1, 0);
    step(1, 3, 1, 0);
    chk("jump_err", 32'(o_step_err), 32'd1);
    chk("jump_cnt", 32'(o_err_cnt), 32'd1);
    step(1, 2, 1, 0);
    chk("resync_err", 32'(o_step_err), 32'd0);
    chk("resync_dir", 32'(o_dir), 32'd1);
    chk("resync_bin", 32'(o_data), 32'd3);

    // Backpressure: outputs frozen while downstream stalls.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_data", 32'(o_data), 32'd0);
      chk("stall_valid", 32'(o_valid), 32'd1);
    end
    step(0, 0, 1, 0);
    chk("drain_valid", 32'(o_valid), 32'd0);
    step(1, 1, 1, 0);

    // Clear with a simultaneous accept, then counter saturation.
    do_reset();
    step(1, 0, 1, 0);
    step(1, 3, 1, 0);
    step(1, 0, 1, 0);
    step(1, 3, 1, 0);
    chk("pre_clr_cnt", 32'(o_err_cnt), 32'd3);
    step(1, 6, 1, 1);
    chk("clr_cnt", 32'(o_err_cnt), 32'd0);
    chk("clr_err", 32'(o_step_err), 32'd0);
    chk("clr_lock", 32'(o_locked), 32'd1);
    for (int i = 0; i < 5; i++) step(1, (i % 2 == 0) ? 5 : 6, 1, 0);
    chk("cnt8_five", 32'(o_err_cnt), 32'd5);
    chk("cnt2_sat", 32'(o_err_cnt2), 32'd3);

    // Reset while a beat is pending.
    do_reset();
    step(1, 1, 1, 0);
    step(1, 3, 0, 0);
    do_reset();
    step(1, 2, 1, 0);
    chk("post_rst_lock", 32'(o_locked), 32'd1);
    chk("post_rst_err", 32'(o_step_err), 32'd0);

    // Random traffic: mostly legal steps, some repeats, jumps, stalls, clears.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bp  = g2b(prev_g);
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      d = b2g((bp + 1) & MASK);
      else if (sel < 7) d = b2g((bp - 1) & MASK);
      else if (sel < 8) d = prev_g;
      else              d = int'($urandom_range(0, MASK));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_stream_decoder.md
GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the code width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the error counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port i_clk SHALL be an input, 1 bit: the single clock, rising edge.
REQ-005 Port i_rstn SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_clr SHALL be an input, 1 bit: synchronous clear of history, state and error count.
REQ-007 Port i_valid SHALL be an input, 1 bit: input beat valid.
REQ-008 Port o_ready SHALL be an output, 1 bit: the block can accept an input beat.
REQ-009 Port i_data SHALL be an input, WIDTH bits: reflected-Gray-coded sample.
REQ-010 Port o_valid SHALL be an output, 1 bit: output beat valid.
REQ-011 Port i_ready SHALL be an input, 1 bit: downstream can accept an output beat.
REQ-012 Port o_data SHALL be an output, WIDTH bits: binary value of the sample.
REQ-013 Port o_dir SHALL be an output, 1 bit: 1 = count up, 0 = count down, relative to the previous sample.
REQ-014 Port o_step_err SHALL be an output, 1 bit: beat violated the single-bit-step rule.
REQ-015 Port o_locked SHALL be an output, 1 bit: a reference sample is held (state TRACK).
REQ-016 Port o_err_cnt SHALL be an output, CNT_W bits: saturating count of step errors.

Function
REQ-017 Input accept SHALL be i_valid && o_ready; output transfer SHALL be o_valid && i_ready.
REQ-018 o_ready SHALL be !o_valid || i_ready, giving a single output register with 1-cycle latency and no bubble under continuous flow.
REQ-019 The decode SHALL be b[WIDTH-1]=g[WIDTH-1] and b[k]=b[k+1]^g[k] for k<WIDTH-1; o_data SHALL be registered on accept.
REQ-020 o_data, o_dir and o_step_err SHALL stay stable while o_valid=1 and i_ready=0.
REQ-021 The FSM SHALL have two states: IDLE (no reference) and TRACK (previous accepted Gray sample held).
REQ-022 An accept in IDLE SHALL store the sample, move to TRACK, emit o_step_err=0 and o_dir=1.
REQ-023 An accept in TRACK SHALL compute the Hamming distance between the new sample and the stored sample.
REQ-024 Hamming distance 1 SHALL give o_step_err=0, with o_dir=1 if bin_new==bin_prev+1 mod 2^WIDTH, else o_dir=0.
REQ-025 The wrap-around steps max->0 (up) and 0->max (down) SHALL be treated as legal steps.
REQ-026 Hamming distance 0 (repeated sample) SHALL give o_step_err=0, with o_dir holding its previous value.
REQ-027 Hamming distance >1 SHALL give o_step_err=1, o_dir=0, and increment o_err_cnt.
REQ-028 After a step error the block SHALL resynchronise: the new sample becomes the reference and the state stays TRACK.
REQ-029 Every accept in TRACK SHALL replace the stored reference with the new sample.
REQ-030 o_err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 o_locked SHALL be 1 exactly when the state is TRACK.
REQ-032 i_clr SHALL set state IDLE, zero o_err_cnt, and leave the output register and o_valid unaffected.
REQ-033 i_clr together with an accept SHALL give clr priority for history: the beat is treated as the first sample (REQ-022), the state ends in TRACK, and o_err_cnt ends at 0.

Reset
REQ-034 While i_rstn=0, the block SHALL asynchronously force o_valid=0, o_data=0, o_dir=0, o_step_err=0, o_locked=0, o_err_cnt=0, state IDLE and reference 0.
REQ-035 After reset, o_ready SHALL be 1, and the first accept after i_rstn deasserts SHALL be handled as an IDLE accept.
REQ-036 Reset mid-transfer SHALL drop any pending output beat.

Verification (WIDTH=3, i_ready=1 unless stated)
REQ-037 Stream Gray 000,001,011,010,110,111,101,100,000 -> o_data 0..7,0 each one cycle later; o_dir=1 from beat 2; o_step_err=0; o_err_cnt=0.
REQ-038 Stream the reverse of that sequence -> o_data 0,7,6..0; o_dir=0 from beat 2; no errors, including the 0->7 wrap.
REQ-039 Accept 000 then 011 (binary 0->2) -> second beat o_step_err=1, o_err_cnt=1; next input 010 (binary 3) -> o_step_err=0, o_dir=1.
REQ-040 Hold i_ready=0 with o_valid=1 for 5 cycles -> o_ready=0 and outputs frozen; i_ready=1 -> one transfer, then o_ready=1.
REQ-041 Apply i_clr in the same cycle as accepting 110 with o_err_cnt=3 -> o_err_cnt=0, o_step_err=0, o_locked=1; CNT_W=2 with 5 errors -> o_err_cnt holds at 3.
REQ-042 Assert i_rstn=0 mid-stream with o_valid=1 -> all outputs 0 immediately; first beat after release -> o_locked=1, o_step_err=0.
